// File: rtl/key_matrix_pkg.sv
// Shared constants for the key matrix: joystick bit layout, joystick row offsets,
// modifier/Fn scancodes and the matrix hit record produced by key_map.
package key_matrix_pkg;

  localparam int JOY_W  = 32;
  localparam int JOY_R  = 0;
  localparam int JOY_L  = 1;
  localparam int JOY_D  = 2;
  localparam int JOY_U  = 3;
  localparam int JOY_B1 = 4;
  localparam int JOY_B2 = 5;
  localparam int JOY_AF = 6;

  localparam int ROWS_PER_JOY = 3;
  localparam int OFS_TOP = 0;
  localparam int OFS_MID = 1;
  localparam int OFS_BOT = 2;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_PRTSC  = 8'h7C;

  // F11 .. F1, F1 in the low byte
  localparam logic [8*11-1:0] SC_FN = {8'h78, 8'h09, 8'h01, 8'h0A, 8'h83, 8'h0B,
                                       8'h03, 8'h0C, 8'h04, 8'h06, 8'h05};

  typedef struct packed {
    logic       valid;
    logic [4:0] row;
    logic [2:0] col;
  } key_hit_t;

  function automatic key_hit_t kh(input int r, input int c);
    key_hit_t h;
    h.valid = 1'b1;
    h.row   = 5'(r);
    h.col   = 3'(c);
    return h;
  endfunction

  function automatic int total_rows(input int n_kb, input int n_joy);
    return n_kb + ROWS_PER_JOY * n_joy;
  endfunction

endpackage

// File: rtl/key_matrix_if.sv
// CPU-side row read port of the key matrix: row select in, registered row data out.
interface key_matrix_if #(
  parameter int ADDR_W = 8,
  parameter int ROW_W  = 8
);
  logic [ADDR_W-1:0] addr;
  logic [ROW_W-1:0]  kb_rows;

  modport master (output addr, input kb_rows);
  modport slave  (input addr, output kb_rows);
endinterface

// File: rtl/key_matrix_map.sv
// Combinational PS/2 {extended, scancode} -> matrix position decoder (no state).
module key_map
  import key_matrix_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output key_hit_t   hit
);

  // E0 arrows, Home and Delete share positions with their numpad legends, so extended
  // codes fall back to the base table; only the E0 fake-shift/PrtSc prefixes are rejected.
  always_comb begin
    hit = '0;
    case (code)
      8'h16: hit = kh(0,0);  8'h1E: hit = kh(0,1);  8'h26: hit = kh(0,2);  8'h25: hit = kh(0,3);
      8'h2E: hit = kh(0,4);  8'h36: hit = kh(0,5);  8'h3D: hit = kh(0,6);  8'h3E: hit = kh(0,7);
      8'h46: hit = kh(1,0);  8'h45: hit = kh(1,1);  8'h4E: hit = kh(1,2);  8'h55: hit = kh(1,3);
      8'h66: hit = kh(1,4);  8'h0D: hit = kh(1,5);  8'h76: hit = kh(1,6);  8'h0E: hit = kh(1,7);
      8'h15: hit = kh(2,0);  8'h1C: hit = kh(2,1);  8'h1D: hit = kh(2,2);  8'h1B: hit = kh(2,3);
      8'h24: hit = kh(2,4);  8'h23: hit = kh(2,5);  8'h2D: hit = kh(2,6);  8'h2B: hit = kh(2,7);
      8'h2C: hit = kh(3,0);  8'h34: hit = kh(3,1);  8'h35: hit = kh(3,2);  8'h33: hit = kh(3,3);
      8'h3C: hit = kh(3,4);  8'h3B: hit = kh(3,5);  8'h43: hit = kh(3,6);  8'h42: hit = kh(3,7);
      8'h44: hit = kh(4,0);  8'h4B: hit = kh(4,1);  8'h4D: hit = kh(4,2);  8'h4C: hit = kh(4,3);
      8'h54: hit = kh(4,4);  8'h52: hit = kh(4,5);  8'h5B: hit = kh(4,6);  8'h5A: hit = kh(4,7);
      8'h1A: hit = kh(5,0);  8'h22: hit = kh(5,1);  8'h21: hit = kh(5,2);  8'h2A: hit = kh(5,3);
      8'h32: hit = kh(5,4);  8'h31: hit = kh(5,5);  8'h3A: hit = kh(5,6);  8'h29: hit = kh(5,7);
      8'h41: hit = kh(6,0);  8'h49: hit = kh(6,1);  8'h75: hit = kh(6,2);  8'h72: hit = kh(6,3);
      8'h6B: hit = kh(6,4);  8'h74: hit = kh(6,5);  8'h4A: hit = kh(6,6);  8'h5D: hit = kh(6,7);
      8'h70: hit = kh(7,0);  8'h69: hit = kh(7,1);  8'h7A: hit = kh(7,2);  8'h73: hit = kh(7,3);
      8'h7D: hit = kh(7,4);  8'h6C: hit = kh(7,5);  8'h71: hit = kh(7,6);  8'h58: hit = kh(7,7);
      SC_ALT:    hit = kh(8,0);  SC_CTRL:   hit = kh(8,1);
      SC_LSHIFT: hit = kh(8,2);  SC_RSHIFT: hit = kh(8,2);
      8'h79: hit = kh(8,3);  8'h7B: hit = kh(8,4);  SC_PRTSC: hit = kh(8,5);
      8'h77: hit = kh(8,6);  8'h7E: hit = kh(8,7);
      default: hit = '0;
    endcase
    if (ext && (code == SC_LSHIFT || code == SC_PRTSC))
      hit = '0;
  end

endmodule

// File: rtl/key_matrix.sv
// PS/2 keyboard plus joystick key matrix with a registered CPU row read port.
// Optional autofire on joystick B1 is built when KEY_AUTOFIRE_EN is defined.
module key_matrix
  import key_matrix_pkg::*;
#(
  parameter int                NUM_KB_ROWS = 9,
  parameter int                NUM_JOY     = 2,
  parameter int                ROW_W       = 8,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] ALL_ADDR    = 8'h30,
  parameter logic [15:0]       AF_DIV      = 16'd50000
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [10:0]              ps2_key,
  input  logic                     kbd_clr,
  input  logic [NUM_JOY*JOY_W-1:0] joy,
  output logic [10:0]              fn_keys,
  output logic [2:0]               modif,
  output logic                     key_event,
  key_matrix_if.slave              cpu
);

  localparam int TOTAL_ROWS = total_rows(NUM_KB_ROWS, NUM_JOY);
  localparam int JOY_ROWS   = TOTAL_ROWS - NUM_KB_ROWS;

  logic             tog_q, armed_q, stb_q, ext_q, prs_q, new_evt;
  logic [7:0]       code_q;
  logic [ROW_W-1:0] kb_q  [NUM_KB_ROWS];
  logic [ROW_W-1:0] kb_d  [NUM_KB_ROWS];
  logic [ROW_W-1:0] joy_q [JOY_ROWS];
  logic [ROW_W-1:0] joy_d [JOY_ROWS];
  logic [10:0]      fn_d;
  logic [2:0]       mod_d;
  logic             ev_d;
  logic [ROW_W-1:0] rd;
  logic             af_phase;
  key_hit_t         hit;

  logic [NUM_JOY*JOY_W-1:0] unused_joy;
  assign unused_joy = joy;

  key_map u_map (.ext(ext_q), .code(code_q), .hit(hit));

  // armed_q keeps the first cycle after reset from treating the toggle bit as an event
  assign new_evt = armed_q && (ps2_key[10] != tog_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q   <= 1'b0;
      armed_q <= 1'b0;
      stb_q   <= 1'b0;
      ext_q   <= 1'b0;
      prs_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      tog_q   <= ps2_key[10];
      armed_q <= 1'b1;
      stb_q   <= new_evt;
      if (new_evt) begin
        code_q <= ps2_key[7:0];
        ext_q  <= ps2_key[8];
        prs_q  <= ps2_key[9];
      end
    end
  end

  always_comb begin
    kb_d  = kb_q;
    fn_d  = fn_keys;
    mod_d = modif;
    ev_d  = 1'b0;
    if (kbd_clr) begin
      for (int r = 0; r < NUM_KB_ROWS; r++) kb_d[r] = '0;
      fn_d  = '0;
      mod_d = '0;
    end else if (stb_q) begin
      for (int r = 0; r < NUM_KB_ROWS; r++)
        for (int c = 0; c < ROW_W; c++)
          if (hit.valid && hit.row == 5'(r) && hit.col == 3'(c)) begin
            ev_d       = ev_d | (kb_q[r][c] != prs_q);
            kb_d[r][c] = prs_q;
          end
      if (!ext_q)
        for (int i = 0; i < 11; i++)
          if (code_q == SC_FN[8*i +: 8]) fn_d[i] = prs_q;
      if (code_q == SC_RSHIFT) mod_d[0] = prs_q;
      if (code_q == SC_ALT)    mod_d[1] = prs_q;
      if (code_q == SC_CTRL)   mod_d[2] = prs_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      kb_q      <= '{default: '0};
      fn_keys   <= '0;
      modif     <= '0;
      key_event <= 1'b0;
    end else begin
      kb_q      <= kb_d;
      fn_keys   <= fn_d;
      modif     <= mod_d;
      key_event <= ev_d;
    end
  end

  function automatic logic [3*ROW_W-1:0] enc_port(input logic [JOY_W-1:0] p, input logic af);
    logic [ROW_W-1:0] top, mid, bot;
    top = '0;
    mid = '0;
    bot = '0;
    if      (p[JOY_U] && p[JOY_L]) begin top[1] = 1'b1; top[5] = 1'b1; end
    else if (p[JOY_D] && p[JOY_L]) begin mid[0] = 1'b1; mid[4] = 1'b1; end
    else if (p[JOY_U] && p[JOY_R]) begin mid[1] = 1'b1; mid[5] = 1'b1; end
    else if (p[JOY_D] && p[JOY_R]) begin bot[1] = 1'b1; bot[5] = 1'b1; end
    else if (p[JOY_U])             begin top[0] = 1'b1; top[4] = 1'b1; end
    else if (p[JOY_D])             begin bot[0] = 1'b1; bot[4] = 1'b1; end
    else if (p[JOY_L])             begin top[2] = 1'b1; top[6] = 1'b1; end
    else if (p[JOY_R])             begin bot[2] = 1'b1; bot[6] = 1'b1; end
    if (p[JOY_B1] || af) begin top[3] = 1'b1; top[7] = 1'b1; end
    if (p[JOY_B2])       begin bot[3] = 1'b1; bot[7] = 1'b1; end
    return {bot, mid, top};
  endfunction

  always_comb begin
    for (int i = 0; i < JOY_ROWS; i++) joy_d[i] = '0;
    for (int j = 0; j < NUM_JOY; j++)
      {joy_d[ROWS_PER_JOY*j + OFS_BOT], joy_d[ROWS_PER_JOY*j + OFS_MID],
       joy_d[ROWS_PER_JOY*j + OFS_TOP]} =
        enc_port(joy[j*JOY_W +: JOY_W], af_phase & joy[j*JOY_W + JOY_AF]);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) joy_q <= '{default: '0};
    else          joy_q <= joy_d;
  end

`ifdef KEY_AUTOFIRE_EN
  logic [15:0] af_cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == 16'd0) begin
      af_cnt   <= AF_DIV - 16'd1;
      af_phase <= ~af_phase;
    end else begin
      af_cnt   <= af_cnt - 16'd1;
    end
  end
`else
  logic [15:0] unused_af_div;
  assign unused_af_div = AF_DIV;
  assign af_phase      = 1'b0;
`endif

  always_comb begin
    rd = '0;
    if (cpu.addr == ALL_ADDR) begin
      for (int r = 0; r < NUM_KB_ROWS; r++) rd = rd | kb_q[r];
      for (int i = 0; i < JOY_ROWS; i++)    rd = rd | joy_q[i];
    end else begin
      for (int r = 0; r < NUM_KB_ROWS; r++)
        if (cpu.addr == ADDR_W'(r + 1)) rd = kb_q[r];
      for (int i = 0; i < JOY_ROWS; i++)
        if (cpu.addr == ADDR_W'(NUM_KB_ROWS + i + 1)) rd = joy_q[i];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) cpu.kb_rows <= '0;
    else          cpu.kb_rows <= rd;
  end

endmodule

// File: tb/tb_key_matrix.sv
// Directed bench for key_matrix: keyboard strobe timing, mapping, modifiers, Fn keys,
// joystick encoding, row addressing, kbd_clr priority and (with KEY_AUTOFIRE_EN) autofire.
module tb_key_matrix;
  import key_matrix_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic        kbd_clr = 1'b0;
  logic [63:0] joy     = '0;
  logic [10:0] fn_keys;
  logic [2:0]  modif;
  logic        key_event;
  logic        tog     = 1'b0;
  int          n_chk   = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          ev_cnt  = 0;

  key_matrix_if #(.ADDR_W(8), .ROW_W(8)) cpu_if ();

  key_matrix #(.AF_DIV(16'd4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .kbd_clr(kbd_clr),
    .joy(joy), .fn_keys(fn_keys), .modif(modif), .key_event(key_event), .cpu(cpu_if)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (key_event === 1'b1) ev_cnt++;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    cpu_if.addr = a;
    step(1);
    chk(tag, 32'(cpu_if.kb_rows), 32'(exp));
  endtask

  task automatic kev(input logic ext, input logic [7:0] code, input logic prs);
    tog     = ~tog;
    ps2_key = {tog, prs, ext, code};
    step(4);
  endtask

  initial begin
    int e0;
    cpu_if.addr = 8'd0;
    step(2);
    chk("rst_rows",  32'(cpu_if.kb_rows), 32'h0);
    chk("rst_fn",    32'(fn_keys), 32'h0);
    chk("rst_modif", 32'(modif), 32'h0);
    chk("rst_event", 32'(key_event), 32'h0);

    // toggle bit already high at release must not look like an event
    tog     = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
    reset_n = 1'b1;
    step(4);
    rd(8'd3, 8'h00, "no_strobe_after_reset");
    chk("no_event_after_reset", 32'(ev_cnt), 32'd0);

    // 9'h11C pressed: event two cycles after toggle, row visible three cycles after
    e0 = ev_cnt;
    tog = ~tog;
    ps2_key = {tog, 1'b1, 9'h11C};
    cpu_if.addr = 8'd3;
    step(1); chk("ev_pre", 32'(key_event), 32'h0);
    step(1); chk("ev_pulse", 32'(key_event), 32'h1);
             chk("row2_early", 32'(cpu_if.kb_rows), 32'h00);
    step(1); chk("row2_a", 32'(cpu_if.kb_rows), 32'h02);
             chk("ev_post", 32'(key_event), 32'h0);
    step(1); chk("ev_once", 32'(ev_cnt - e0), 32'd1);

    e0 = ev_cnt;
    kev(1'b1, 8'h1C, 1'b1);
    rd(8'd3, 8'h02, "repeat_row");
    chk("repeat_no_event", 32'(ev_cnt - e0), 32'd0);

    kev(1'b1, 8'h75, 1'b1); rd(8'd7, 8'h04, "e0_up");
    kev(1'b1, 8'h75, 1'b0); rd(8'd7, 8'h00, "e0_up_rel");
    kev(1'b0, 8'h75, 1'b1); rd(8'd7, 8'h04, "kp8");
    kev(1'b0, 8'h75, 1'b0); rd(8'd7, 8'h00, "kp8_rel");

    e0 = ev_cnt;
    kev(1'b1, 8'h12, 1'b1);
    rd(8'd9, 8'h00, "fake_shift_ignored");
    chk("fake_shift_no_event", 32'(ev_cnt - e0), 32'd0);

    kev(1'b0, 8'h12, 1'b1);
    rd(8'd9, 8'h04, "lshift_row");
    chk("lshift_modif", 32'(modif), 32'h0);
    e0 = ev_cnt;
    kev(1'b0, 8'h59, 1'b1);
    rd(8'd9, 8'h04, "rshift_row");
    chk("rshift_modif", 32'(modif), 32'h1);
    chk("rshift_no_event", 32'(ev_cnt - e0), 32'd0);
    kev(1'b0, 8'h59, 1'b0);
    chk("rshift_rel_modif", 32'(modif), 32'h0);
    kev(1'b0, 8'h12, 1'b0);
    rd(8'd9, 8'h00, "shift_rel_row");
    kev(1'b0, 8'h14, 1'b1);
    rd(8'd9, 8'h02, "ctrl_row");
    chk("ctrl_modif", 32'(modif), 32'h4);

    e0 = ev_cnt;
    kev(1'b0, 8'h05, 1'b1); chk("fn_f1", 32'(fn_keys), 32'h001);
    kev(1'b0, 8'h78, 1'b1); chk("fn_f11", 32'(fn_keys), 32'h401);
    kev(1'b0, 8'h83, 1'b1); chk("fn_f7", 32'(fn_keys), 32'h441);
    chk("fn_no_event", 32'(ev_cnt - e0), 32'd0);

    // toggles on consecutive cycles: Q then W, both must land
    e0 = ev_cnt;
    tog = ~tog; ps2_key = {tog, 1'b1, 1'b0, 8'h15};
    step(1);
    tog = ~tog; ps2_key = {tog, 1'b1, 1'b0, 8'h1D};
    step(4);
    rd(8'd3, 8'h07, "back_to_back_row");
    chk("back_to_back_events", 32'(ev_cnt - e0), 32'd2);

    joy = {32'h0, 32'h0000000A}; step(1);
    rd(8'd10, 8'h22, "joy_ul");
    rd(8'd11, 8'h00, "joy_ul_mid");
    rd(8'h30, 8'h27, "all_rows_or");
    joy = {32'h00000025, 32'h00000010}; step(1);
    rd(8'd10, 8'h88, "joy0_b1");
    rd(8'd13, 8'h00, "joy1_top_dr");
    rd(8'd15, 8'hAA, "joy1_dr_b2");
    joy = {32'h0000000F, 32'h0}; step(1);
    rd(8'd13, 8'h22, "joy1_all_dirs_ul");
    rd(8'd14, 8'h00, "joy1_all_dirs_mid");
    rd(8'd10, 8'h00, "joy0_idle");
    joy = {32'h00000006, 32'h0}; step(1);
    rd(8'd14, 8'h11, "joy1_dl");
    joy = {32'h00000001, 32'h0}; step(1);
    rd(8'd15, 8'h44, "joy1_r");
    joy = {32'h00000004, 32'h0}; step(1);
    rd(8'd15, 8'h11, "joy1_d");
    rd(8'd16, 8'h00, "addr_past_end");
    rd(8'd0,  8'h00, "addr_zero");

    // kbd_clr in the same cycle as the strobe for B
    joy = {32'h0, 32'h0000000A}; step(1);
    tog = ~tog; ps2_key = {tog, 1'b1, 1'b0, 8'h32};
    step(1);
    kbd_clr = 1'b1;
    step(1);
    kbd_clr = 1'b0;
    step(2);
    rd(8'd3, 8'h00, "clr_row2");
    rd(8'd6, 8'h00, "clr_beats_strobe");
    rd(8'd9, 8'h00, "clr_row8");
    chk("clr_fn", 32'(fn_keys), 32'h0);
    chk("clr_modif", 32'(modif), 32'h0);
    rd(8'h30, 8'h22, "clr_all_joy_only");
    rd(8'd10, 8'h22, "clr_joy_kept");
    kev(1'b0, 8'h32, 1'b1);
    rd(8'd6, 8'h10, "press_after_clr");

    // autofire: reset released at a known point so the phase is deterministic
    reset_n = 1'b0;
    joy = {32'h0, 32'h00000040};
    cpu_if.addr = 8'd10;
    step(2);
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
`ifdef KEY_AUTOFIRE_EN
      chk($sformatf("autofire_k%0d", k), 32'(cpu_if.kb_rows),
          ((k >= 3 && k <= 6) || k >= 11) ? 32'h88 : 32'h00);
`else
      chk($sformatf("af_ignored_k%0d", k), 32'(cpu_if.kb_rows), 32'h00);
`endif
    end
    reset_n = 1'b0;
    #1;
    chk("async_reset_rows", 32'(cpu_if.kb_rows), 32'h00);
    chk("async_reset_event", 32'(key_event), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_matrix.md
KEY_MATRIX -- requirements
Module: key_matrix

Interface
REQ-001 Parameter NUM_KB_ROWS, 9, keyboard matrix rows driven from PS/2.
REQ-002 Parameter NUM_JOY, 2, joystick ports; each occupies 3 matrix rows after the keyboard rows.
REQ-003 Parameter ROW_W, 8, bits per matrix row.
REQ-004 Parameter ADDR_W, 8, CPU address width.
REQ-005 Parameter ALL_ADDR, 8'h30, address returning the OR of all rows.
REQ-006 Parameter AF_DIV, 16'd50000, autofire half-period in clk_sys cycles.
REQ-007 clk_sys  in  1  system clock; single clock domain.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 ps2_key  in  11  [7:0] scancode, [8] extended, [9] pressed, [10] toggles per event.
REQ-010 kbd_clr  in  1  synchronous one-cycle pulse clearing keyboard state.
REQ-011 addr  in  ADDR_W  CPU row select.
REQ-012 joy  in  NUM_JOY*32  packed joysticks; per port [0]R [1]L [2]D [3]U [4]B1 [5]B2 [6]autofire.
REQ-013 kb_rows  out  ROW_W  registered row data.
REQ-014 fn_keys  out  11  F1..F11 held state.
REQ-015 modif  out  3  [0] right shift, [1] alt, [2] ctrl held state.
REQ-016 key_event  out  1  one-cycle pulse when any keyboard matrix bit changes.

Function
REQ-017 ps2_key[10] SHALL be registered; an inequality with the registered copy raises an internal strobe on the next cycle, latching code, extended and pressed.
REQ-018 A keyboard bit, fn_keys bit or modif bit SHALL take the pressed value in the cycle after the strobe (2 cycles after the ps2_key[10] toggle).
REQ-019 Lookup SHALL use {extended, scancode}; E0-prefixed arrows, Home and Delete map to their keys; an unmapped code changes nothing.
REQ-020 Left and right shift both drive row 8 bit 2; only right shift drives modif[0].
REQ-021 key_event SHALL pulse only if the write altered a bit; a repeated press of a held key produces no pulse.
REQ-022 Joystick rows SHALL be recomputed every cycle from joy. Base row b = NUM_KB_ROWS + 3j; directions are priority-ordered UL, DL, UR, DR, U, D, L, R; only the first match is encoded.
REQ-023 Direction encoding: UL b bits 1,5; DL b+1 bits 0,4; UR b+1 bits 1,5; DR b+2 bits 1,5; U b bits 0,4; D b+2 bits 0,4; L b bits 2,6; R b+2 bits 2,6.
REQ-024 B1 SHALL set row b bits 3,7 and B2 row b+2 bits 3,7, each independent of direction.
REQ-025 kb_rows SHALL update one cycle after addr: ALL_ADDR gives the OR of all rows; 1..TOTAL_ROWS gives row addr-1; any other address gives 0.
REQ-026 kbd_clr SHALL zero the keyboard rows, fn_keys and modif; joystick rows are unaffected. If kbd_clr coincides with a strobe, kbd_clr wins.
REQ-027 A strobe arriving while kbd_clr is low SHALL never be dropped; back-to-back toggles on consecutive cycles each apply in order.

Reset
REQ-028 reset_n low SHALL asynchronously clear all rows, kb_rows, fn_keys, modif, key_event, the strobe, the toggle copy and the autofire counter.
REQ-029 After reset release, the first cycle SHALL capture ps2_key[10] without generating a strobe.

Configuration
REQ-030 With KEY_AUTOFIRE_EN defined: a counter to AF_DIV toggles a phase bit, and for each port with joy[6] high, B1 is ORed with the phase.
REQ-031 Without KEY_AUTOFIRE_EN: joy[6] is ignored and no counter is synthesised.

Structure
REQ-032 Package key_matrix_pkg SHALL hold the joystick bit indices, row offsets, modifier/Fn scancodes and the TOTAL_ROWS function.
REQ-033 Sub-module key_map SHALL be a combinational {ext,code} -> {valid,row,bit} decoder; all state stays in key_matrix.

Verification
REQ-034 Toggle ps2_key with 9'h11C, pressed=1, then addr=3 -> kb_rows=8'h02 three cycles after the toggle; key_event pulses once.
REQ-035 Extended 8'h75 pressed, addr=7 -> kb_rows bit 2 set; non-extended 8'h75 -> same bit (numpad 8).
REQ-036 joy[3:0]=4'b1010 (UL) on port 0, addr=10 -> 8'h22; addr=11 -> 8'h00; addr=ALL_ADDR includes 8'h22.
REQ-037 Hold A, then kbd_clr coincident with a strobe for B -> rows 0..8 are all zero and joystick rows are unchanged.
REQ-038 With KEY_AUTOFIRE_EN, AF_DIV=4 and joy[6]=1 -> row 10 bits 3,7 toggle every 4 cycles; reset_n low mid-period clears them immediately.
